// File: rtl/seed_loader.sv
// seed_loader: host-side sequencer that streams 64-bit seeds into every
// (node, base) slot of the node random units and unloads them back.
module seed_loader #(
    parameter int node_num = 2,
    parameter int base_num = 4,
    parameter int base_log = (base_num > 1) ? $clog2(base_num) : 1,
    parameter int node_log = (node_num > 1) ? $clog2(node_num) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_wr,
    input  logic                         start_rd,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [63:0]                  s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [63:0]                  m_data,
    output logic [base_log-1:0]          base_id,
    output logic [node_num-1:0]          init,
    output logic [63:0]                  w_seed,
    output logic [node_num-1:0]          read,
    input  logic [node_num-1:0][63:0]    r_seed,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [2:0] {
        IDLE, WR, RD_ADDR, RD_READ, RD_CAP, RD_OUT
    } state_t;

    state_t                state_q;
    logic [base_log-1:0]   base_q, base_d;
    logic [node_log-1:0]   node_q, node_d;
    logic [63:0]           m_data_q;
    logic                  s_ready_q, m_valid_q, busy_q, done_q;
    logic [node_num-1:0]   node_oh;
    logic                  last;

    // slot-order successor: base is the inner index, node the outer one
    always_comb begin
        base_d = base_q + base_log'(1);
        node_d = node_q;
        last   = (base_q == base_log'(base_num - 1)) &&
                 (node_q == node_log'(node_num - 1));
        if (base_q == base_log'(base_num - 1)) begin
            base_d = '0;
            node_d = (node_q == node_log'(node_num - 1)) ? '0 : node_q + node_log'(1);
        end
        for (int i = 0; i < node_num; i++) begin
            node_oh[i] = (node_q == node_log'(i));
        end
    end

    // sequencer: state, slot counters, captured read data and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            node_q    <= '0;
            m_data_q  <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_wr) begin
                        state_q   <= WR;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                        base_q    <= '0;
                        node_q    <= '0;
                    end else if (start_rd) begin
                        state_q <= RD_ADDR;
                        busy_q  <= 1'b1;
                        base_q  <= '0;
                        node_q  <= '0;
                    end
                end
                WR: begin
                    if (s_valid) begin
                        base_q <= base_d;
                        node_q <= node_d;
                        if (last) begin
                            state_q   <= IDLE;
                            s_ready_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                RD_ADDR: state_q <= RD_READ;
                RD_READ: state_q <= RD_CAP;
                RD_CAP: begin
                    m_data_q  <= r_seed[node_q];
                    m_valid_q <= 1'b1;
                    state_q   <= RD_OUT;
                end
                RD_OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        base_q    <= base_d;
                        node_q    <= node_d;
                        if (last) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RD_ADDR;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // strobes decode from the registered state; init also needs the host beat
    always_comb begin
        init   = (s_ready_q && s_valid) ? node_oh : '0;
        w_seed = s_ready_q ? s_data : 64'd0;
        read   = (state_q == RD_READ) ? node_oh : '0;
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign base_id = base_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
